vram_write_scheduler: RTL
=========================

Name: vram_write_scheduler

Overview:
- Queues CPU writes to VRAM (PMB 0x200–0x3FF, NTBL 0x400–0x7FF) that arrive at any time, including during active display.
- Replays them in order only while the video timing reports the VRAM writable, so no CPU write is silently lost outside vblank.
- Sits between the CPU bus decode and the background/foreground VRAM write ports, on the CPU clock domain.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, `VRAM_ADDR_WIDTH (12), VRAM address width.

Ports:
- cpu_clk  input  1  sole clock; all state updates on posedge, qualified by cpu_clk_enable.
- rst_n  input  1  reset, asynchronous, active-low.
- cpu_clk_enable  input  1  clock enable; no state changes when 0.
- writable  input  1  from video timing; VRAM may be written this cycle.
- cpu_write_enable  input  1  CPU write request.
- cpu_address  input  ADDR_W  CPU write address.
- cpu_data  input  8  CPU write data.
- cpu_ready  output  1  high when a push will be accepted this cycle.
- vram_write_enable  output  1  registered VRAM write strobe.
- vram_address  output  ADDR_W  registered VRAM address.
- vram_data  output  8  registered VRAM data.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a write was dropped.
- overflow_clear  input  1  clears overflow.
- fill_start  input  1  request nametable fill (feature only).
- fill_value  input  8  fill byte (feature only).
- fill_busy  output  1  fill in progress (feature only).

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_count=0, overflow=0, vram_write_enable=0, vram_address=0, vram_data=0, fill_busy=0, state=IDLE.
- Effective cycle: a posedge with cpu_clk_enable=1. Every rule below counts effective cycles only.
- Push condition: cpu_write_enable && cpu_ready. The entry {cpu_address, cpu_data} is stored at the tail.
- cpu_ready rule: cpu_ready = !full || pop_this_cycle (combinational). A push while full with a simultaneous pop is accepted and the count is unchanged.
- Overflow: cpu_write_enable while cpu_ready=0 drops the write and sets overflow.
  - overflow_clear clears it.
  - If a set and a clear occur in the same cycle, set wins.
- Addresses outside 0x200–0x7FF are still queued; the downstream decode ignores them.
- Pop and drive:
  - In DRAIN, each effective cycle with writable=1 and the FIFO non-empty pops the head.
  - The popped entry is registered onto vram_* with vram_write_enable=1 for exactly one effective cycle. Otherwise vram_write_enable=0.
  - vram_address and vram_data hold their last values when vram_write_enable=0.
- Latency: a push into an empty FIFO with writable=1 appears on vram_* two effective cycles later (cycle N push, N+1 pop, strobe visible N+1..N+2). Order is strictly FIFO.
- Downstream samples on negedge cpu_clk. The registered outputs are therefore stable across the sampling edge.
- States:
  - IDLE: go to DRAIN when the FIFO is non-empty. Go to FILL when fill_start is asserted (feature only).
  - DRAIN: pops only while writable=1. If writable drops mid-drain, stay in DRAIN with no strobe; resume when writable returns. Go to IDLE when the FIFO becomes empty and no push occurred this cycle.
  - FILL: see Optional Feature.
- Wrap-around: read and write pointers are DEPTH-modulo. full/empty are derived from fifo_count.
- Reset mid-operation discards all queued entries and aborts any fill.

Optional Feature:
- Macro VRAM_WRITE_SCHEDULER_FILL_EN.
- Defined:
  - fill_start in IDLE or DRAIN (when not busy) latches fill_value, sets fill_busy=1 and enters FILL at the next effective cycle.
  - FILL writes fill_value to 0x400..0x7BF (960 bytes, one per effective cycle), only while writable=1. The counter pauses while writable=0.
  - The FIFO keeps accepting pushes during FILL but does not drain.
  - After writing 0x7BF: fill_busy=0, then go to DRAIN if the FIFO is non-empty, else IDLE.
  - fill_start while fill_busy=1 is ignored.
  - 0x7C0 (color register) is never touched.
- Undefined: fill_start and fill_value are ignored, fill_busy is tied 0, and the FILL state does not exist.

Test Plan:
- Reset, writable=1, push (0x405,0xAB) -> vram_write_enable=1 with vram_address=0x405, vram_data=0xAB two effective cycles after the push, for one cycle; fifo_count returns to 0.
- writable=0, push 16 writes (0x200+i, i) -> cpu_ready=0, fifo_count=16. Raise writable -> 16 strobes in order 0x200..0x20F on consecutive effective cycles.
- Full FIFO, writable=0, push 0x300 -> dropped, overflow=1, fifo_count=16. overflow_clear -> overflow=0.
- Full FIFO, writable=1, push 0x7C0 in the same cycle as a pop -> accepted, count stays 16, and 0x7C0 is emitted last.
- cpu_clk_enable=0 for 5 cycles with pending data and writable=1 -> no strobe, no count change. Assert rst_n=0 mid-drain -> all outputs 0 immediately, FIFO empty.
- (FILL_EN) fill_start with fill_value=0x1F, writable toggling 100 on/100 off -> exactly 960 strobes covering 0x400..0x7BF, none outside writable, fill_busy falls after 0x7BF, and a queued (0x210,0x55) is emitted afterwards.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// rtl/vram_write_scheduler.sv - CPU-to-VRAM write queue replayed only while video timing allows
//
// Purpose:
//   Buffers CPU VRAM writes in a DEPTH-entry FIFO and replays them in order,
//   one per effective cycle, only while 'writable' is high. An optional
//   nametable fill engine writes one byte to every address in 0x400..0x7BF.
//   The fill engine is compiled in only when VRAM_WRITE_SCHEDULER_FILL_EN is defined.
//
// Ports:
//   cpu_clk, rst_n        clock, async active-low reset
//   cpu_clk_enable        qualifies every state update
//   writable              VRAM may be written this cycle
//   cpu_write_enable,
//   cpu_address, cpu_data CPU write request
//   cpu_ready             push accepted this cycle
//   vram_write_enable,
//   vram_address,
//   vram_data             registered VRAM write port
//   fifo_count            occupancy
//   overflow,
//   overflow_clear        sticky dropped-write flag and its clear
//   fill_start,
//   fill_value, fill_busy nametable fill control (fill build only)

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_scheduler #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = `VRAM_ADDR_WIDTH
) (
  input  logic                     cpu_clk,
  input  logic                     rst_n,
  input  logic                     cpu_clk_enable,
  input  logic                     writable,
  input  logic                     cpu_write_enable,
  input  logic [ADDR_W-1:0]        cpu_address,
  input  logic [7:0]               cpu_data,
  output logic                     cpu_ready,
  output logic                     vram_write_enable,
  output logic [ADDR_W-1:0]        vram_address,
  output logic [7:0]               vram_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clear,
  input  logic                     fill_start,
  input  logic [7:0]               fill_value,
  output logic                     fill_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef VRAM_WRITE_SCHEDULER_FILL_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FILL  = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;
`endif

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [7:0]        r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;

  logic              r_overflow;
  logic              r_vram_we;
  logic [ADDR_W-1:0] r_vram_addr;
  logic [7:0]        r_vram_data;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_fill_go;
  logic              w_fill_wr;
  logic              w_fill_last;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [7:0]        w_fill_data;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Only DRAIN pops; during FILL the queue holds so fill bytes and CPU
  // writes never interleave.
  assign w_pop     = (r_state == S_DRAIN) && writable && !w_empty;
  assign cpu_ready = !w_full || w_pop;
  assign w_push    = cpu_write_enable && cpu_ready;
  assign w_drop    = cpu_write_enable && !cpu_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

`ifdef VRAM_WRITE_SCHEDULER_FILL_EN
  localparam logic [ADDR_W-1:0] FILL_FIRST = ADDR_W'(12'h400);
  localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(12'h7BF);

  logic [ADDR_W-1:0] r_fill_addr;
  logic [7:0]        r_fill_value;

  // A request while already filling is ignored.
  assign w_fill_go   = fill_start && (r_state != S_FILL);
  assign w_fill_wr   = (r_state == S_FILL) && writable;
  assign w_fill_last = w_fill_wr && (r_fill_addr == FILL_LAST);
  assign w_fill_addr = r_fill_addr;
  assign w_fill_data = r_fill_value;
  assign fill_busy   = (r_state == S_FILL);

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_addr  <= '0;
      r_fill_value <= '0;
    end else if (cpu_clk_enable) begin
      if (w_fill_go) begin
        r_fill_addr  <= FILL_FIRST;
        r_fill_value <= fill_value;
      end else if (w_fill_wr) begin
        r_fill_addr  <= r_fill_addr + ADDR_W'(1);
      end
    end
  end
`else
  logic w_unused_fill;

  assign w_unused_fill = &{1'b0, fill_start, fill_value};
  assign w_fill_go     = 1'b0;
  assign w_fill_wr     = 1'b0;
  assign w_fill_last   = 1'b0;
  assign w_fill_addr   = '0;
  assign w_fill_data   = '0;
  assign fill_busy     = 1'b0;
`endif

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (cpu_clk_enable) begin
      r_state <= w_state_next;
    end
  end

  // Transitions look at the post-cycle occupancy so a push into an empty
  // queue is already in DRAIN on the next cycle (two-cycle latency).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fill_go) begin
`ifdef VRAM_WRITE_SCHEDULER_FILL_EN
          w_state_next = S_FILL;
`endif
        end else if (w_count_next != '0) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_fill_go) begin
`ifdef VRAM_WRITE_SCHEDULER_FILL_EN
          w_state_next = S_FILL;
`endif
        end else if (w_count_next == '0) begin
          w_state_next = S_IDLE;
        end
      end
`ifdef VRAM_WRITE_SCHEDULER_FILL_EN
      S_FILL: begin
        if (w_fill_last) begin
          w_state_next = (w_count_next != '0) ? S_DRAIN : S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge cpu_clk) begin
    if (cpu_clk_enable && w_push) begin
      r_mem_addr[r_wr_ptr] <= cpu_address;
      r_mem_data[r_wr_ptr] <= cpu_data;
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_vram_we   <= 1'b0;
      r_vram_addr <= '0;
      r_vram_data <= '0;
    end else if (cpu_clk_enable) begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;

      // A drop in the same cycle as a clear must stay visible.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clear) begin
        r_overflow <= 1'b0;
      end

      // Address/data hold between strobes.
      if (w_pop) begin
        r_vram_we   <= 1'b1;
        r_vram_addr <= r_mem_addr[r_rd_ptr];
        r_vram_data <= r_mem_data[r_rd_ptr];
      end else if (w_fill_wr) begin
        r_vram_we   <= 1'b1;
        r_vram_addr <= w_fill_addr;
        r_vram_data <= w_fill_data;
      end else begin
        r_vram_we   <= 1'b0;
      end
    end
  end

  assign vram_write_enable = r_vram_we;
  assign vram_address      = r_vram_addr;
  assign vram_data         = r_vram_data;
  assign fifo_count        = r_count;
  assign overflow          = r_overflow;

endmodule
